// File: rtl/alu_pkg.sv
// ALU operation encodings and flag bundle shared by the EX-stage pipelined ALU.
package alu_pkg;

  localparam int ALU_OPCODE_LENGTH = 4;

  typedef enum logic [ALU_OPCODE_LENGTH-1:0] {
    ALU_AND  = 4'b0000,
    ALU_OR   = 4'b0001,
    ALU_ADD  = 4'b0010,
    ALU_XOR  = 4'b0011,
    ALU_SLL  = 4'b0100,
    ALU_SRL  = 4'b0101,
    ALU_SUB  = 4'b0110,
    ALU_SLT  = 4'b0111,
    ALU_SLTU = 4'b1000,
    ALU_SRA  = 4'b1001
  } alu_op_e;

  typedef struct packed {
    logic zero;
    logic carry;
    logic overflow;
    logic illegal;
  } flags_t;

endpackage

// File: rtl/alu_pipe_unit_core.sv
// Combinational ALU datapath: one operation plus zero/carry/overflow/illegal flags.
module alu_core
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = ALU_OPCODE_LENGTH
) (
  input  logic [DATA_WIDTH-1:0]    a_i,
  input  logic [DATA_WIDTH-1:0]    b_i,
  input  logic [OPCODE_LENGTH-1:0] op_i,
  output logic [DATA_WIDTH-1:0]    result_o,
  output flags_t                   flags_o
);

  localparam int SHW = $clog2(DATA_WIDTH);
  localparam int MSB = DATA_WIDTH - 1;

  logic                  is_sub;
  logic [DATA_WIDTH-1:0] b_eff;
  logic [DATA_WIDTH:0]   sum;
  logic [SHW-1:0]        shamt;
  logic                  add_ovf;

  // SUB shares the adder as A + ~B + 1, so carry out means "no borrow"
  assign is_sub  = (op_i == OPCODE_LENGTH'(ALU_SUB));
  assign b_eff   = is_sub ? ~b_i : b_i;
  assign sum     = {1'b0, a_i} + {1'b0, b_eff} + {{DATA_WIDTH{1'b0}}, is_sub};
  assign shamt   = b_i[SHW-1:0];
  assign add_ovf = (a_i[MSB] == b_eff[MSB]) && (sum[MSB] != a_i[MSB]);

  always_comb begin
    result_o         = '0;
    flags_o          = '0;
    case (op_i)
      OPCODE_LENGTH'(ALU_AND):  result_o = a_i & b_i;
      OPCODE_LENGTH'(ALU_OR):   result_o = a_i | b_i;
      OPCODE_LENGTH'(ALU_XOR):  result_o = a_i ^ b_i;
      OPCODE_LENGTH'(ALU_SLL):  result_o = a_i << shamt;
      OPCODE_LENGTH'(ALU_SRL):  result_o = a_i >> shamt;
      OPCODE_LENGTH'(ALU_SRA):  result_o = $unsigned($signed(a_i) >>> shamt);
      OPCODE_LENGTH'(ALU_SLT):  result_o = {{(DATA_WIDTH-1){1'b0}}, $signed(a_i) < $signed(b_i)};
      OPCODE_LENGTH'(ALU_SLTU): result_o = {{(DATA_WIDTH-1){1'b0}}, a_i < b_i};
      OPCODE_LENGTH'(ALU_ADD), OPCODE_LENGTH'(ALU_SUB): begin
        result_o         = sum[MSB:0];
        flags_o.carry    = sum[DATA_WIDTH];
        flags_o.overflow = add_ovf;
      end
      default:                  flags_o.illegal = 1'b1;
    endcase
    flags_o.zero = (result_o == '0);
  end

endmodule

// File: rtl/alu_pipe_unit.sv
// Pipelined EX-stage ALU: result computed before stage 1, later stages only delay,
// valid/ready handshake with bubble collapsing and a synchronous flush.
module alu_pipe_unit
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = ALU_OPCODE_LENGTH,
  parameter int STAGES        = 2,
  parameter int TAG_WIDTH     = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_WIDTH-1:0]    SrcA,
  input  logic [DATA_WIDTH-1:0]    SrcB,
  input  logic [OPCODE_LENGTH-1:0] Operation,
  input  logic [TAG_WIDTH-1:0]     in_tag,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_WIDTH-1:0]    ALUResult,
  output logic [TAG_WIDTH-1:0]     out_tag,
  output logic                     Zero,
  output logic                     Carry,
  output logic                     Overflow,
  output logic                     Illegal
);

  logic [DATA_WIDTH-1:0] core_res;
  flags_t                core_flags;

  alu_core #(
    .DATA_WIDTH    (DATA_WIDTH),
    .OPCODE_LENGTH (OPCODE_LENGTH)
  ) u_core (
    .a_i      (SrcA),
    .b_i      (SrcB),
    .op_i     (Operation),
    .result_o (core_res),
    .flags_o  (core_flags)
  );

  logic [STAGES-1:0]     valid_q, valid_d;
  logic [STAGES-1:0]     ready;
  logic [STAGES-1:0]     load;
  logic [DATA_WIDTH-1:0] res_q [STAGES];
  logic [TAG_WIDTH-1:0]  tag_q [STAGES];
  flags_t                flg_q [STAGES];

  // ready_k = !valid_k || ready_{k+1}, unrolled as an OR accumulated from the output end
  always_comb begin
    logic acc;
    acc   = out_ready;
    ready = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      acc      = acc | ~valid_q[k];
      ready[k] = acc;
    end
  end

  always_comb begin
    valid_d = valid_q;
    load    = '0;
    if (flush) begin
      valid_d = '0;
    end else begin
      if (ready[0]) begin
        valid_d[0] = in_valid;
        load[0]    = in_valid;
      end
      for (int k = 1; k < STAGES; k++) begin
        if (ready[k]) begin
          valid_d[k] = valid_q[k-1];
          load[k]    = valid_q[k-1];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int k = 0; k < STAGES; k++) begin
        res_q[k] <= '0;
        tag_q[k] <= '0;
        flg_q[k] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      if (load[0]) begin
        res_q[0] <= core_res;
        tag_q[0] <= in_tag;
        flg_q[0] <= core_flags;
      end
      for (int k = 1; k < STAGES; k++) begin
        if (load[k]) begin
          res_q[k] <= res_q[k-1];
          tag_q[k] <= tag_q[k-1];
          flg_q[k] <= flg_q[k-1];
        end
      end
    end
  end

  assign in_ready  = ready[0];
  assign out_valid = valid_q[STAGES-1];
  assign ALUResult = res_q[STAGES-1];
  assign out_tag   = tag_q[STAGES-1];
  assign Zero      = flg_q[STAGES-1].zero;
  assign Carry     = flg_q[STAGES-1].carry;
  assign Overflow  = flg_q[STAGES-1].overflow;
  assign Illegal   = flg_q[STAGES-1].illegal;

endmodule

// File: tb/tb_alu_pipe_unit.sv
// Directed-vector bench for alu_pipe_unit (STAGES=2, 32-bit): ops, flags, stall, flush, reset.
module tb_alu_pipe_unit;

  localparam int STAGES = 2;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] SrcA, SrcB, ALUResult;
  logic [3:0]  Operation;
  logic [4:0]  in_tag, out_tag;
  logic        Zero, Carry, Overflow, Illegal;

  alu_pipe_unit #(
    .DATA_WIDTH(32), .OPCODE_LENGTH(4), .STAGES(STAGES), .TAG_WIDTH(5)
  ) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .SrcA(SrcA), .SrcB(SrcB), .Operation(Operation), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .ALUResult(ALUResult), .out_tag(out_tag),
    .Zero(Zero), .Carry(Carry), .Overflow(Overflow), .Illegal(Illegal)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] tg);
    in_valid  = 1'b1;
    Operation = op;
    SrcA      = a;
    SrcB      = b;
    in_tag    = tg;
  endtask

  function automatic logic [31:0] flg();
    return {28'd0, Zero, Carry, Overflow, Illegal};
  endfunction

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a, b, res;
    logic [3:0]  fl;   // {zero, carry, overflow, illegal}
  } vec_t;

  vec_t        vt[12];
  logic [31:0] exp_q[$];
  logic [4:0]  etag_q[$];
  int          sent, got;
  bit          held, saw_bp;
  logic [31:0] hres;
  logic [4:0]  htag;

  initial begin
    vt[0]  = '{4'b0000, 32'hF0F0_00FF, 32'h0FF0_0F0F, 32'h00F0_000F, 4'b0000};
    vt[1]  = '{4'b0001, 32'hF0F0_00FF, 32'h0FF0_0F0F, 32'hFFF0_0FFF, 4'b0000};
    vt[2]  = '{4'b0011, 32'hF0F0_00FF, 32'h0FF0_0F0F, 32'hFF00_0FF0, 4'b0000};
    vt[3]  = '{4'b0100, 32'h0000_0003, 32'h0000_0021, 32'h0000_0006, 4'b0000};
    vt[4]  = '{4'b0101, 32'h8000_0000, 32'h0000_001F, 32'h0000_0001, 4'b0000};
    vt[5]  = '{4'b0111, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 4'b0000};
    vt[6]  = '{4'b1000, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 4'b1000};
    vt[7]  = '{4'b0110, 32'h0000_0003, 32'h0000_0005, 32'hFFFF_FFFE, 4'b0000};
    vt[8]  = '{4'b0110, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 4'b0110};
    vt[9]  = '{4'b0010, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 4'b1100};
    vt[10] = '{4'b1111, 32'h1234_5678, 32'h0000_0001, 32'h0000_0000, 4'b1001};
    vt[11] = '{4'b1001, 32'h7FFF_FFF0, 32'h0000_0004, 32'h07FF_FFFF, 4'b0000};

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    SrcA = '0; SrcB = '0; Operation = '0; in_tag = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    step();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_result", ALUResult, 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_flags", flg(), 32'd0);

    // ADD signed overflow, two-cycle latency
    drive(4'b0010, 32'h7FFF_FFFF, 32'h1, 5'd5);
    step();
    in_valid = 1'b0;
    check("add_lat_v", 32'(out_valid), 32'd0);
    step();
    check("add_v", 32'(out_valid), 32'd1);
    check("add_res", ALUResult, 32'h8000_0000);
    check("add_flags", flg(), 32'b0010);
    check("add_tag", 32'(out_tag), 32'd5);

    // SUB then SRA back-to-back
    drive(4'b0110, 32'd5, 32'd5, 5'd1);
    step();
    drive(4'b1001, 32'h8000_0000, 32'h24, 5'd2);
    step();
    in_valid = 1'b0;
    check("sub_v", 32'(out_valid), 32'd1);
    check("sub_res", ALUResult, 32'd0);
    check("sub_flags", flg(), 32'b1100);
    check("sub_tag", 32'(out_tag), 32'd1);
    step();
    check("sra_v", 32'(out_valid), 32'd1);
    check("sra_res", ALUResult, 32'hF800_0000);
    check("sra_flags", flg(), 32'b0000);
    check("sra_tag", 32'(out_tag), 32'd2);
    step();
    check("drain_v", 32'(out_valid), 32'd0);

    // full-rate stream of the vector table
    for (int j = 0; j < 12 + STAGES - 1; j++) begin
      if (j < 12) drive(vt[j].op, vt[j].a, vt[j].b, 5'(j + 1));
      else in_valid = 1'b0;
      step();
      if (j >= STAGES - 1) begin
        check($sformatf("vec%0d_v", j - STAGES + 1), 32'(out_valid), 32'd1);
        check($sformatf("vec%0d_res", j - STAGES + 1), ALUResult, vt[j - STAGES + 1].res);
        check($sformatf("vec%0d_flags", j - STAGES + 1), flg(), 32'(vt[j - STAGES + 1].fl));
        check($sformatf("vec%0d_tag", j - STAGES + 1), 32'(out_tag), 32'(j - STAGES + 2));
      end
    end
    in_valid = 1'b0;
    step();

    // stall: out_ready low for three cycles mid-stream
    sent = 0; got = 0; held = 1'b0; saw_bp = 1'b0;
    for (int c = 0; c < 30 && got < 4; c++) begin
      out_ready = !(c >= 2 && c <= 4);
      in_valid  = (sent < 4);
      Operation = 4'b0010;
      SrcA      = 32'(32'h100 * (sent + 1));
      SrcB      = 32'(sent);
      in_tag    = 5'(10 + sent);
      #1;
      if (held) begin
        check("hold_v", 32'(out_valid), 32'd1);
        check("hold_res", ALUResult, hres);
        check("hold_tag", 32'(out_tag), 32'(htag));
      end
      if (in_valid && !in_ready) saw_bp = 1'b1;
      if (in_valid && in_ready) begin
        exp_q.push_back(SrcA + SrcB);
        etag_q.push_back(in_tag);
        sent++;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("stall_extra", 32'd1, 32'd0);
        else begin
          check("stall_res", ALUResult, exp_q.pop_front());
          check("stall_tag", 32'(out_tag), 32'(etag_q.pop_front()));
        end
        got++;
      end
      held = out_valid && !out_ready;
      hres = ALUResult;
      htag = out_tag;
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    check("stall_count", 32'(got), 32'd4);
    check("stall_backpressure", 32'(saw_bp), 32'd1);
    step();
    check("stall_dup", 32'(out_valid), 32'd0);

    // flush with two ops in flight and a third presented
    out_ready = 1'b0;
    drive(4'b0010, 32'd1, 32'd1, 5'd20);
    step();
    drive(4'b0010, 32'd2, 32'd2, 5'd21);
    step();
    drive(4'b0010, 32'd3, 32'd3, 5'd22);
    flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    check("flush_v0", 32'(out_valid), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("flush_v%0d", i + 1), 32'(out_valid), 32'd0);
    end

    // flush beats load into an empty pipe
    drive(4'b0010, 32'd4, 32'd4, 5'd23);
    flush = 1'b1;
    #1;
    check("flush_rdy", 32'(in_ready), 32'd1);
    step();
    flush = 1'b0; in_valid = 1'b0;
    check("flushld_v0", 32'(out_valid), 32'd0);
    step();
    check("flushld_v1", 32'(out_valid), 32'd0);

    drive(4'b0010, 32'd2, 32'd3, 5'd24);
    step();
    in_valid = 1'b0;
    check("post_flush_lat", 32'(out_valid), 32'd0);
    step();
    check("post_flush_v", 32'(out_valid), 32'd1);
    check("post_flush_res", ALUResult, 32'd5);
    check("post_flush_tag", 32'(out_tag), 32'd24);
    step();

    // asynchronous reset mid-stream
    drive(4'b0010, 32'd1, 32'd1, 5'd7);
    step();
    drive(4'b0000, 32'hFF, 32'h0F, 5'd8);
    step();
    check("pre_rst_v", 32'(out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_v", 32'(out_valid), 32'd0);
    check("async_rst_res", ALUResult, 32'd0);
    check("async_rst_tag", 32'(out_tag), 32'd0);
    in_valid = 1'b0;
    #2 rst_n = 1'b1;
    step();
    check("post_rst_rdy", 32'(in_ready), 32'd1);
    check("post_rst_v0", 32'(out_valid), 32'd0);
    step();
    check("post_rst_v1", 32'(out_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
